// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding and frame/baud defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int BIT_END      = 8;
    localparam int BAUD_END_DEF = 5207;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a history flop for falling-edge detection.
// Latency: line change visible on rx_sync two sclk edges later; rx_fall is combinational from the flops.
// Backpressure: none; free-running sampler.
module uart_rx_sync (
    input  logic sclk,
    input  logic s_rst_n,
    input  logic rx_async,
    output logic rx_sync,
    output logic rx_fall
);

    logic sync1;
    logic sync2;
    logic sync3;

    // Reset to the idle level so release never looks like a start edge.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= rx_async;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rx_sync = sync2;
    assign rx_fall = !sync2 && sync3;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver writing bytes into a FIFO; optional stop-bit check under UART_RX_FRAME_CHK_EN.
// Latency: write strobe one sclk after the mid-stop-bit sample (about 9.5 bit times after the start edge).
// Backpressure: wfifo_full at the stop sample drops the byte and pulses ovf_err; the line is never stalled.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_END = BAUD_END_DEF
) (
    input  logic       sclk,
    input  logic       s_rst_n,
    input  logic       rs232_rx,
    input  logic       wfifo_full,
    output logic       wfifo_wr_en,
    output logic [7:0] wfifo_wr_data,
    output logic       rx_busy,
    output logic       ovf_err,
    output logic       frm_err
);

    localparam int         BAUD_M   = BAUD_END / 2 - 1;
    localparam logic [12:0] BAUD_END_C = 13'(BAUD_END);
    localparam logic [12:0] BAUD_M_C   = 13'(BAUD_M);
    localparam logic [3:0]  BIT_LAST   = 4'(BIT_END - 1);

    logic        rx_s;
    logic        rx_fall;
    rx_state_t   state;
    logic [12:0] baud_cnt;
    logic [12:0] baud_nxt;
    logic [3:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        stop_ok;

    uart_rx_sync u_sync (
        .sclk     (sclk),
        .s_rst_n  (s_rst_n),
        .rx_async (rs232_rx),
        .rx_sync  (rx_s),
        .rx_fall  (rx_fall)
    );

    always_comb begin
        baud_nxt = baud_cnt + 13'd1;
        if (baud_cnt == BAUD_END_C) begin
            baud_nxt = 13'd0;
        end
    end

`ifdef UART_RX_FRAME_CHK_EN
    assign stop_ok = rx_s;
`else
    assign stop_ok = 1'b1;
    assign frm_err = 1'b0;
`endif

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state         <= IDLE;
            baud_cnt      <= 13'd0;
            bit_cnt       <= 4'd0;
            shreg         <= 8'h00;
            rx_busy       <= 1'b0;
            wfifo_wr_en   <= 1'b0;
            wfifo_wr_data <= 8'h00;
            ovf_err       <= 1'b0;
`ifdef UART_RX_FRAME_CHK_EN
            frm_err       <= 1'b0;
`endif
        end else begin
            wfifo_wr_en <= 1'b0;
            ovf_err     <= 1'b0;
`ifdef UART_RX_FRAME_CHK_EN
            frm_err     <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    baud_cnt <= 13'd0;
                    bit_cnt  <= 4'd0;
                    if (rx_fall) begin
                        state   <= START;
                        rx_busy <= 1'b1;
                    end
                end
                START: begin
                    baud_cnt <= baud_nxt;
                    if (baud_cnt == BAUD_M_C && rx_s) begin
                        // Line back high at mid start bit: glitch, not a frame.
                        state    <= IDLE;
                        rx_busy  <= 1'b0;
                        baud_cnt <= 13'd0;
                    end else if (baud_cnt == BAUD_END_C) begin
                        state   <= DATA;
                        bit_cnt <= 4'd0;
                    end
                end
                DATA: begin
                    baud_cnt <= baud_nxt;
                    if (baud_cnt == BAUD_M_C) begin
                        shreg <= {rx_s, shreg[7:1]};
                    end
                    if (baud_cnt == BAUD_END_C) begin
                        if (bit_cnt == BIT_LAST) begin
                            state   <= STOP;
                            bit_cnt <= 4'd0;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                STOP: begin
                    baud_cnt <= baud_nxt;
                    if (baud_cnt == BAUD_M_C) begin
                        // Idle from mid stop bit so a back-to-back start edge is caught.
                        state    <= IDLE;
                        rx_busy  <= 1'b0;
                        baud_cnt <= 13'd0;
                        if (stop_ok) begin
                            if (wfifo_full) begin
                                ovf_err <= 1'b1;
                            end else begin
                                wfifo_wr_en   <= 1'b1;
                                wfifo_wr_data <= shreg;
                            end
                        end else begin
`ifdef UART_RX_FRAME_CHK_EN
                            frm_err <= 1'b1;
`endif
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx with BAUD_END=56: directed frames, glitch, overflow, bad stop bit, mid-frame reset.
// Expected events are queued with the cycle they must appear on; a monitor pops and compares.
module tb_uart_rx;

    localparam int BEND    = 56;
    localparam int BIT_CYC = BEND + 1;
    // Line drop after edge N -> sync (2) -> START at N+3 -> 9 bit periods -> mid stop (+28) -> strobe.
    localparam int WR_LAT  = 3 + 9 * BIT_CYC + 28;

    localparam int K_WR  = 0;
    localparam int K_OVF = 1;
    localparam int K_FRM = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       sclk;
    logic       s_rst_n;
    logic       rs232_rx;
    logic       wfifo_full;
    logic       wfifo_wr_en;
    logic [7:0] wfifo_wr_data;
    logic       rx_busy;
    logic       ovf_err;
    logic       frm_err;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb_q[$];

    uart_rx #(.BAUD_END(BEND)) dut (
        .sclk          (sclk),
        .s_rst_n       (s_rst_n),
        .rs232_rx      (rs232_rx),
        .wfifo_full    (wfifo_full),
        .wfifo_wr_en   (wfifo_wr_en),
        .wfifo_wr_data (wfifo_wr_data),
        .rx_busy       (rx_busy),
        .ovf_err       (ovf_err),
        .frm_err       (frm_err)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    always @(posedge sclk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: every output event must match the head of the scoreboard.
    always @(negedge sclk) begin
        if (s_rst_n && (wfifo_wr_en || ovf_err || frm_err)) begin
            int   obs_kind;
            exp_t e;
            obs_kind = wfifo_wr_en ? K_WR : (ovf_err ? K_OVF : K_FRM);
            check("event_single", int'(wfifo_wr_en) + int'(ovf_err) + int'(frm_err), 1);
            if (sb_q.size() == 0) begin
                check("unexpected_event_kind", obs_kind, -1);
            end else begin
                e = sb_q.pop_front();
                check("event_kind", obs_kind, e.kind);
                check("event_cycle", cyc, e.cyc);
                if (e.kind == K_WR) begin
                    check("wr_data", int'(wfifo_wr_data), int'(e.data));
                end
            end
        end
    end

    // Call aligned at #1 after a posedge; returns aligned the same way with the line idle.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int kind);
        exp_t e;
        rs232_rx = 1'b0;
        e.kind = kind;
        e.data = b;
        e.cyc  = cyc + WR_LAT;
        if (kind >= 0) sb_q.push_back(e);
        repeat (BIT_CYC) @(posedge sclk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rs232_rx = b[i];
            repeat (BIT_CYC) @(posedge sclk);
            #1;
        end
        rs232_rx = stop_bit;
        repeat (BIT_CYC) @(posedge sclk);
        #1;
        rs232_rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"}, int'(wfifo_wr_en), 0);
        check({tag, "_wr_data"}, int'(wfifo_wr_data), 0);
        check({tag, "_rx_busy"}, int'(rx_busy), 0);
        check({tag, "_ovf_err"}, int'(ovf_err), 0);
        check({tag, "_frm_err"}, int'(frm_err), 0);
    endtask

    initial begin
        int busy_cnt;
        rs232_rx   = 1'b1;
        wfifo_full = 1'b0;
        s_rst_n    = 1'b0;
        idle(3);
        check_reset_outputs("reset");
        s_rst_n = 1'b1;
        idle(20);

        // Good frame 0x55
        send_byte(8'h55, 1'b1, K_WR);
        idle(100);

        // 10-cycle low glitch: busy for exactly 28 cycles, no output
        busy_cnt = 0;
        rs232_rx = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            @(posedge sclk);
            #1;
            if (i == 10) rs232_rx = 1'b1;
            if (rx_busy) busy_cnt++;
        end
        check("glitch_busy_cycles", busy_cnt, 28);
        idle(40);

        // Back-to-back frames, no idle gap
        send_byte(8'hA3, 1'b1, K_WR);
        send_byte(8'h0F, 1'b1, K_WR);
        idle(100);

        // FIFO full: overflow pulse instead of write
        wfifo_full = 1'b1;
        send_byte(8'h81, 1'b1, K_OVF);
        idle(10);
        wfifo_full = 1'b0;
        idle(90);

        // Bad stop bit
`ifdef UART_RX_FRAME_CHK_EN
        send_byte(8'h3C, 1'b0, K_FRM);
`else
        send_byte(8'h3C, 1'b0, K_WR);
`endif
        idle(100);

        // Reset during data bit 4 of 0x55 (bit 4 is high)
        rs232_rx = 1'b0;
        idle(BIT_CYC);
        for (int i = 0; i < 4; i++) begin
            rs232_rx = (i % 2 == 0) ? 1'b1 : 1'b0;
            idle(BIT_CYC);
        end
        rs232_rx = 1'b1;
        idle(20);
        check("busy_before_mid_reset", int'(rx_busy), 1);
        s_rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        idle(5);
        s_rst_n = 1'b1;
        idle(BIT_CYC * 12);
        check("busy_after_reset_release", int'(rx_busy), 0);

        send_byte(8'hC7, 1'b1, K_WR);
        idle(200);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
